pattern_detector_param: RTL and testbench
=========================================

// Module: pattern_detector_param
// PURPOSE
//  Serial bit-stream pattern detector with a run-time programmable pattern (1..PAT_WIDTH bits),
//  selectable overlapping/non-overlapping detection, input qualifier and saturating match counter.
//  Replaces fixed-pattern detector FSMs in the serial-input front end; one instance per stream.
// PARAMETERS
//  PAT_WIDTH  4  max pattern length in bits (>=2)
//  LEN_W      3  width of cfg_len; must satisfy 2**LEN_W > PAT_WIDTH
//  CNT_WIDTH  8  width of match_count (>=1)
// PORTS
//  clk          in   1          rising-edge clock
//  rst_n        in   1          asynchronous active-low reset
//  cfg_we       in   1          load cfg_pattern/cfg_len/cfg_overlap this edge
//  cfg_pattern  in   PAT_WIDTH  pattern; bit [len-1] = first bit received, bit [0] = last
//  cfg_len      in   LEN_W      pattern length; 0 -> 1, >PAT_WIDTH -> PAT_WIDTH (clamped at load)
//  cfg_overlap  in   1          1 = overlapping detection, 0 = non-overlapping
//  cnt_clr      in   1          synchronous clear of match_count
//  in_valid     in   1          in_bit is sampled only when high
//  in_bit       in   1          serial data bit
//  match        out  1          one-cycle pulse: pattern just completed
//  match_count  out  CNT_WIDTH  number of matches, saturates at all-ones
//  active_len   out  LEN_W      clamped pattern length in use
// BEHAVIOUR
//  Reset (rst_n low, async): match=0, match_count=0, history=0, fill=0, pattern reg=0,
//   active_len=PAT_WIDTH, overlap reg=1. Outputs are held at these values while rst_n is low.
//  State: history[PAT_WIDTH-1:0] shift register; fill counter 0..active_len (saturating).
//  Sample edge (in_valid=1, cfg_we=0): history <= {history[PAT_WIDTH-2:0], in_bit};
//   fill <= min(fill+1, active_len).
//  Compare: let H be the history value after the shift. Only the low active_len bits of H and
//   of the pattern register are compared.
//   Hit = (fill_next == active_len) && (H masked == pattern masked).
//  match is registered: it is 1 in the cycle after the edge that sampled the last pattern bit.
//   It is 0 in every other cycle, including edges where in_valid=0.
//  On a hit with overlap=1: history and fill advance normally, so suffix reuse is allowed.
//  On a hit with overlap=0: fill <= 0, so the next match needs active_len fresh bits.
//  match_count increments by 1 on each hit and holds at 2**CNT_WIDTH-1.
//  cnt_clr: match_count <= 0. If a hit occurs on the same edge, the clear wins (count=0).
//  cfg_we: loads the config registers; history <= 0, fill <= 0, match <= 0. in_bit is ignored
//   on that edge. match_count is unaffected.
//  Back-to-back valid bits are allowed every cycle; there is no backpressure.
//  active_len=1: every valid bit equal to pattern[0] produces a hit.
//  Reset mid-stream discards partial progress. The first post-reset match needs active_len
//   valid bits.
// TESTING
//  T1 defaults, then cfg 4'b1101 len4 ovl=1; stream 1,1,0,1,1,0,1 (all valid)
//   -> match after bits 4 and 7; count=2.
//  T2 same pattern, ovl=0; stream 1,1,0,1,1,0,1 -> match after bit 4 only.
//   Continue with 1,1,0,1 -> second match after bit 11; count=2.
//  T3 in_valid gaps: 1101 spread over 9 cycles, in_valid low between bits
//   -> single 1-cycle match after the 4th valid bit; no match on idle cycles.
//  T4 cfg 3'b111 len3 ovl=1; stream 1,1,1,1,1 -> 3 matches.
//   Then cfg_len=0 with pattern[0]=0; stream 0,1,0 -> 2 matches.
//  T5 CNT_WIDTH=2: 5 matches -> count saturates at 3.
//   cnt_clr coincident with a hit -> count=0, match still pulses.
//  T6 rst_n low asynchronously after 3 bits of 1101 (between edges) -> outputs 0 immediately.
//   After release, bits "1" then "101" -> match only after 4 post-reset bits; cfg back to defaults.

Source files
------------

// File: rtl/pattern_detector_param.sv
// Serial bit-stream pattern detector with a run-time programmable pattern of 1..PAT_WIDTH bits.
// It supports overlapping or non-overlapping detection and keeps a saturating match counter.
module pattern_detector_param #(
  parameter int PAT_WIDTH = 4,
  parameter int LEN_W     = 3,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_we,
  input  logic [PAT_WIDTH-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 cnt_clr,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 match,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [LEN_W-1:0]     active_len
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_WIDTH);

  logic [PAT_WIDTH-1:0] history_reg;
  logic [PAT_WIDTH-1:0] history_next;
  logic [PAT_WIDTH-1:0] pattern_reg;
  logic [PAT_WIDTH-1:0] len_mask;
  logic [LEN_W-1:0]     fill_reg;
  logic [LEN_W-1:0]     fill_next;
  logic [LEN_W-1:0]     len_reg;
  logic [LEN_W-1:0]     len_clamped;
  logic                 overlap_reg;
  logic                 match_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 hit;

  // Only the newest len_reg history bits take part in the comparison.
  generate
    for (genvar gi = 0; gi < PAT_WIDTH; gi++) begin : g_mask
      assign len_mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  always_comb begin
    len_clamped = cfg_len;
    if (cfg_len == '0)
      len_clamped = LEN_W'(1);
    else if (cfg_len > MAX_LEN)
      len_clamped = MAX_LEN;
  end

  assign history_next = {history_reg[PAT_WIDTH-2:0], in_bit};
  assign fill_next    = (fill_reg >= len_reg) ? len_reg : fill_reg + LEN_W'(1);
  assign hit          = in_valid && !cfg_we && (fill_next == len_reg) &&
                        (((history_next ^ pattern_reg) & len_mask) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_reg <= '0;
      fill_reg    <= '0;
      pattern_reg <= '0;
      len_reg     <= MAX_LEN;
      overlap_reg <= 1'b1;
      match_reg   <= 1'b0;
      count_reg   <= '0;
    end else begin
      match_reg <= hit;
      if (cfg_we) begin
        pattern_reg <= cfg_pattern;
        len_reg     <= len_clamped;
        overlap_reg <= cfg_overlap;
        history_reg <= '0;
        fill_reg    <= '0;
      end else if (in_valid) begin
        history_reg <= history_next;
        // Non-overlapping mode restarts the fill so the next match needs fresh bits.
        fill_reg    <= (hit && !overlap_reg) ? '0 : fill_next;
      end
      if (cnt_clr)
        count_reg <= '0;
      else if (hit && (count_reg != '1))
        count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign match       = match_reg;
  assign match_count = count_reg;
  assign active_len  = len_reg;

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: directed scenarios plus a randomized run checked against
// a queue-based model of the received bit stream. A 2-bit-counter instance exercises saturation.
module tb_pattern_detector_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we, cfg_overlap, cnt_clr, in_valid, in_bit;
  logic [3:0] cfg_pattern;
  logic [2:0] cfg_len;
  logic       m1, m2;
  logic [7:0] c1;
  logic [1:0] c2;
  logic [2:0] al1, al2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: bits received since the last restart point.
  bit         q[$];
  logic [3:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         exp_match;
  int         exp_cnt, exp_cnt_s;

  always #5 clk = ~clk;

  pattern_detector_param #(.PAT_WIDTH(4), .LEN_W(3), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_bit(in_bit),
    .match(m1), .match_count(c1), .active_len(al1));

  pattern_detector_param #(.PAT_WIDTH(4), .LEN_W(3), .CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .in_valid(in_valid), .in_bit(in_bit),
    .match(m2), .match_count(c2), .active_len(al2));

  task automatic model_reset();
    q.delete();
    m_pat = 4'b0000; m_len = 4; m_ovl = 1'b1;
    exp_match = 1'b0; exp_cnt = 0; exp_cnt_s = 0;
  endtask

  task automatic model_edge(input bit we, input logic [3:0] pat, input logic [2:0] len,
                            input bit ovl, input bit clr, input bit v, input bit b);
    bit hit = 1'b0;
    if (we) begin
      q.delete();
      m_pat = pat;
      m_len = (len == 0) ? 1 : ((len > 4) ? 4 : int'(len));
      m_ovl = ovl;
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 4) void'(q.pop_front());
      if (q.size() >= m_len) begin
        hit = 1'b1;
        for (int i = 0; i < m_len; i++)
          if (q[q.size()-1-i] != m_pat[i]) hit = 1'b0;
      end
      if (hit && !m_ovl) q.delete();
    end
    exp_match = hit;
    if (clr) begin
      exp_cnt = 0; exp_cnt_s = 0;
    end else if (hit) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_cnt_s < 3) exp_cnt_s++;
    end
  endtask

  // Drive one clock edge worth of inputs, then advance the model; outputs are read at edge+1.
  task automatic step(input bit we, input logic [3:0] pat, input logic [2:0] len, input bit ovl,
                      input bit clr, input bit v, input bit b);
    cfg_we = we; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    cnt_clr = clr; in_valid = v; in_bit = b;
    @(posedge clk);
    #1;
    model_edge(we, pat, len, ovl, clr, v, b);
    cyc++;
    $display("cyc %0d we=%0b pat=%b len=%0d ovl=%0b clr=%0b v=%0b b=%0b -> match=%0b count=%0d cnt_s=%0d alen=%0d",
             cyc, we, pat, len, ovl, clr, v, b, m1, c1, c2, al1);
  endtask

  task automatic bit_step(input bit v, input bit b);
    step(1'b0, 4'b0000, 3'd0, 1'b1, 1'b0, v, b);
  endtask

  task automatic cfg_step(input logic [3:0] pat, input logic [2:0] len, input bit ovl, input bit clr);
    step(1'b1, pat, len, ovl, clr, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cfg_we = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0; cnt_clr = 0;
    in_valid = 1; in_bit = 0;
    model_reset();
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if (m1 !== 1'b0 || c1 !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs: match=%0b count=%0d, required 0/0", m1, c1);
    end
    n_checks++;
    if (al1 !== 3'd4 || al2 !== 3'd4) begin
      n_fail++; $display("FAIL reset_active_len: got %0d/%0d, required 4", al1, al2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 0;
  endtask

  task automatic test_overlap();
    bit bits[7] = '{1, 1, 0, 1, 1, 0, 1};
    bit expm[7] = '{0, 0, 0, 1, 0, 0, 1};
    cfg_step(4'b1101, 3'd4, 1'b1, 1'b0);
    n_checks++;
    if (m1 !== 1'b0 || al1 !== 3'd4) begin
      n_fail++; $display("FAIL ovl_cfg: match=%0b alen=%0d, required 0/4", m1, al1);
    end
    for (int i = 0; i < 7; i++) begin
      bit_step(1'b1, bits[i]);
      n_checks++;
      if (m1 !== expm[i]) begin
        n_fail++; $display("FAIL ovl_match bit%0d: got %0b, required %0b", i + 1, m1, expm[i]);
      end
    end
    n_checks++;
    if (c1 !== 8'd2) begin
      n_fail++; $display("FAIL ovl_count: got %0d, required 2", c1);
    end
  endtask

  task automatic test_non_overlap();
    bit bits[11] = '{1, 1, 0, 1, 1, 0, 1, 1, 1, 0, 1};
    bit expm[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    cfg_step(4'b1101, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      bit_step(1'b1, bits[i]);
      n_checks++;
      if (m1 !== expm[i]) begin
        n_fail++; $display("FAIL novl_match bit%0d: got %0b, required %0b", i + 1, m1, expm[i]);
      end
    end
    n_checks++;
    if (c1 !== 8'd2) begin
      n_fail++; $display("FAIL novl_count: got %0d, required 2", c1);
    end
  endtask

  task automatic test_valid_gaps();
    bit vld[9]  = '{1, 0, 1, 0, 1, 0, 0, 1, 0};
    bit bits[9] = '{1, 0, 1, 0, 0, 0, 0, 1, 0};
    bit expm[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    cfg_step(4'b1101, 3'd4, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      bit_step(vld[i], vld[i] ? bits[i] : 1'($urandom_range(0, 1)));
      n_checks++;
      if (m1 !== expm[i]) begin
        n_fail++; $display("FAIL gaps_match cyc%0d: got %0b, required %0b", i + 1, m1, expm[i]);
      end
    end
    n_checks++;
    if (c1 !== 8'd1) begin
      n_fail++; $display("FAIL gaps_count: got %0d, required 1", c1);
    end
  endtask

  task automatic test_short_len();
    bit bits1[3] = '{0, 1, 0};
    bit expm1[3] = '{1, 0, 1};
    cfg_step(4'b0111, 3'd3, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_step(1'b1, 1'b1);
      n_checks++;
      if (m1 !== (i >= 2)) begin
        n_fail++; $display("FAIL len3_match bit%0d: got %0b, required %0b", i + 1, m1, (i >= 2));
      end
    end
    n_checks++;
    if (c1 !== 8'd3) begin
      n_fail++; $display("FAIL len3_count: got %0d, required 3", c1);
    end
    cfg_step(4'b1110, 3'd0, 1'b1, 1'b1);
    n_checks++;
    if (al1 !== 3'd1) begin
      n_fail++; $display("FAIL len0_clamp: got %0d, required 1", al1);
    end
    for (int i = 0; i < 3; i++) begin
      bit_step(1'b1, bits1[i]);
      n_checks++;
      if (m1 !== expm1[i]) begin
        n_fail++; $display("FAIL len1_match bit%0d: got %0b, required %0b", i + 1, m1, expm1[i]);
      end
    end
    n_checks++;
    if (c1 !== 8'd2) begin
      n_fail++; $display("FAIL len1_count: got %0d, required 2", c1);
    end
    cfg_step(4'b1010, 3'd7, 1'b1, 1'b0);
    n_checks++;
    if (al1 !== 3'd4) begin
      n_fail++; $display("FAIL len7_clamp: got %0d, required 4", al1);
    end
  endtask

  task automatic test_saturate_clear();
    cfg_step(4'b0001, 3'd1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_step(1'b1, 1'b1);
      n_checks++;
      if (m2 !== 1'b1 || c2 !== 2'((i < 3) ? i + 1 : 3)) begin
        n_fail++; $display("FAIL sat_count hit%0d: match=%0b count=%0d, required 1/%0d",
                           i + 1, m2, c2, (i < 3) ? i + 1 : 3);
      end
    end
    step(1'b0, 4'b0000, 3'd0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (m1 !== 1'b1 || c1 !== 8'd0 || c2 !== 2'd0) begin
      n_fail++; $display("FAIL clr_vs_hit: match=%0b count=%0d cnt_s=%0d, required 1/0/0", m1, c1, c2);
    end
    bit_step(1'b1, 1'b1);
    n_checks++;
    if (c1 !== 8'd1) begin
      n_fail++; $display("FAIL after_clr_count: got %0d, required 1", c1);
    end
  endtask

  task automatic test_async_reset();
    bit bits[3] = '{1, 1, 0};
    bit post[4] = '{1, 1, 0, 1};
    cfg_step(4'b1101, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) bit_step(1'b1, bits[i]);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (m1 !== 1'b0 || c1 !== 8'd0 || al1 !== 3'd4) begin
      n_fail++; $display("FAIL async_reset: match=%0b count=%0d alen=%0d, required 0/0/4", m1, c1, al1);
    end
    in_valid = 1'b1; in_bit = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (m1 !== 1'b0 || c1 !== 8'd0) begin
      n_fail++; $display("FAIL reset_hold: match=%0b count=%0d, required 0/0", m1, c1);
    end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit_step(1'b1, 1'b0);
      n_checks++;
      if (m1 !== (i == 3)) begin
        n_fail++; $display("FAIL post_reset_default bit%0d: got %0b, required %0b", i + 1, m1, (i == 3));
      end
    end
    cfg_step(4'b1101, 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      bit_step(1'b1, post[i]);
      n_checks++;
      if (m1 !== (i == 3)) begin
        n_fail++; $display("FAIL post_reset_1101 bit%0d: got %0b, required %0b", i + 1, m1, (i == 3));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bit we  = ($urandom_range(0, 24) == 0);
      bit clr = ($urandom_range(0, 29) == 0);
      bit v   = ($urandom_range(0, 3) != 0);
      step(we, 4'($urandom), 3'($urandom), 1'($urandom), clr, v, 1'($urandom));
      n_checks++;
      if (m1 !== exp_match || m2 !== exp_match) begin
        n_fail++; $display("FAIL rnd_match cyc%0d: got %0b/%0b, required %0b", cyc, m1, m2, exp_match);
      end
      n_checks++;
      if (c1 !== 8'(exp_cnt) || c2 !== 2'(exp_cnt_s)) begin
        n_fail++; $display("FAIL rnd_count cyc%0d: got %0d/%0d, required %0d/%0d",
                           cyc, c1, c2, exp_cnt, exp_cnt_s);
      end
      n_checks++;
      if (al1 !== 3'(m_len)) begin
        n_fail++; $display("FAIL rnd_alen cyc%0d: got %0d, required %0d", cyc, al1, m_len);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gaps();
    test_short_len();
    test_saturate_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
